// File: rtl/main_memory_responder.sv
// Main-memory responder below the cache refill port.
// Block reads return critical-word-first bursts; byte writes are acked.
module main_memory_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int LATENCY     = 3
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           MemReq,
  input  logic                           MemRWB,
  input  logic [ADDR_W-1:0]              MemAddr,
  input  logic [DATA_W-1:0]              MemWData,
  output logic                           MemBusy,
  output logic                           MemValid,
  output logic [DATA_W-1:0]              MemRData,
  output logic [$clog2(BLOCK_BYTES)-1:0] MemWordIdx,
  output logic                           MemWAck
);

  localparam int IW    = $clog2(BLOCK_BYTES);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(LATENCY + BLOCK_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} st_t;

  st_t               st, st_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [IW-1:0]     off, off_d;
  logic              rwb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              valid_d;
  logic [DATA_W-1:0] rdata_d;
  logic [IW-1:0]     idx_d;
  logic              wack_d;
  logic              we;
  logic              accept;
  logic [ADDR_W-1:0] rd_addr;

  assign accept  = (st == IDLE) && MemReq;
  // off walks the block; the high bits stay pinned to the latched block
  assign rd_addr = {addr_q[ADDR_W-1:IW], off};

  always_ff @(posedge Clk) begin
    if (Reset) st <= IDLE;
    else       st <= st_d;
  end

  always_comb begin
    st_d = st;
    unique case (st)
      IDLE:  if (MemReq) st_d = WAIT;
      WAIT:  if (cnt == '0) st_d = rwb_q ? BURST : WACK;
      BURST: if (cnt == '0) st_d = IDLE;
      WACK:  st_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt;
    off_d   = off;
    valid_d = 1'b0;
    rdata_d = '0;
    idx_d   = '0;
    wack_d  = 1'b0;
    we      = 1'b0;
    unique case (st)
      IDLE: begin
        if (MemReq) begin
          cnt_d = CW'(LATENCY - 1);
          off_d = MemAddr[IW-1:0];
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (rwb_q) begin
          valid_d = 1'b1;
          rdata_d = mem[rd_addr];
          idx_d   = off;
          off_d   = off + 1'b1;
          cnt_d   = CW'(BLOCK_BYTES - 1);
        end else begin
          we     = 1'b1;
          wack_d = 1'b1;
        end
      end
      BURST: begin
        if (cnt != '0) begin
          valid_d = 1'b1;
          rdata_d = mem[rd_addr];
          idx_d   = off;
          off_d   = off + 1'b1;
          cnt_d   = cnt - 1'b1;
        end
      end
      WACK: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt        <= '0;
      off        <= '0;
      rwb_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      MemBusy    <= 1'b0;
      MemValid   <= 1'b0;
      MemRData   <= '0;
      MemWordIdx <= '0;
      MemWAck    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= DATA_W'(i);
    end else begin
      cnt        <= cnt_d;
      off        <= off_d;
      MemBusy    <= (st_d != IDLE);
      MemValid   <= valid_d;
      MemRData   <= rdata_d;
      MemWordIdx <= idx_d;
      MemWAck    <= wack_d;
      if (accept) begin
        rwb_q   <= MemRWB;
        addr_q  <= MemAddr;
        wdata_q <= MemWData;
      end
      if (we) mem[addr_q] <= wdata_q;
    end
  end

endmodule
